// File: rtl/btn_debounce_bank.sv
// Push-button conditioner: per-bit 2-FF synchroniser, counter debounce and press-pulse detect.
// Optional BTN_ONEHOT_EN serialises simultaneous presses through a pending register, lowest index first.
module btn_debounce_bank #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pulse_q, pulse_d;
  logic [N_BTN-1:0] rise_d;
  logic [CNT_W-1:0] cnt_q [N_BTN];
  logic [CNT_W-1:0] cnt_d [N_BTN];

`ifdef BTN_ONEHOT_EN
  logic [N_BTN-1:0] pending_q, pending_d;
  logic [N_BTN-1:0] grant;
`endif

  // Each bit counts consecutive cycles that the synchronised input disagrees
  // with the accepted level; any agreement restarts the count.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    level_d = level_q;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = level_d & ~level_q;
  end

`ifdef BTN_ONEHOT_EN
  // Two's-complement trick isolates the lowest pending bit.
  always_comb begin
    grant     = pending_q & (~pending_q + N_BTN'(1));
    pending_d = (pending_q & ~grant) | rise_d;
    pulse_d   = grant;
  end
`else
  always_comb begin
    pulse_d = rise_d;
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pulse_q <= '0;
      // NOTE: the counter array is small and must restart on reset, so each entry is cleared explicitly.
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      for (int i = 0; i < N_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef BTN_ONEHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end
`endif

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Bench for btn_debounce_bank (DEBOUNCE_CYCLES=4): directed spec scenarios plus random presses,
// compared every cycle against a sliding-window reference model; honours BTN_ONEHOT_EN.
module tb_btn_debounce_bank;

  localparam int D = 4;
`ifdef BTN_ONEHOT_EN
  localparam int ONEHOT = 1;
`else
  localparam int ONEHOT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = '0;
  logic [3:0] btn_level, btn_pulse;

  btn_debounce_bank #(.N_BTN(4), .DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .clk      (clk),
    .reset    (reset),
    .btn_raw  (btn_raw),
    .btn_level(btn_level),
    .btn_pulse(btn_pulse)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int edge_no = 0;
  int pulse_cnt [4];
  int first_pulse [4];

  // Reference model: raw passes through two sample stages; a bit's level flips
  // once the last D visible samples all disagree with it.
  logic [3:0] m_s1, m_s2, m_level, m_pulse, m_pend;
  logic [3:0] m_win [D];

  task automatic model_edge(input logic [3:0] raw, input logic rst);
    logic [3:0] new_level, rise;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_pulse = '0; m_pend = '0;
      for (int j = 0; j < D; j++) m_win[j] = '0;
    end else begin
      for (int j = D - 1; j > 0; j--) m_win[j] = m_win[j-1];
      m_win[0] = m_s2;
      new_level = m_level;
      for (int b = 0; b < 4; b++) begin
        bit all_diff = 1'b1;
        for (int j = 0; j < D; j++) if (m_win[j][b] == m_level[b]) all_diff = 1'b0;
        if (all_diff) new_level[b] = ~m_level[b];
      end
      rise = new_level & ~m_level;
      m_level = new_level;
      if (ONEHOT != 0) begin
        logic [3:0] g = '0;
        for (int b = 0; b < 4; b++) if (m_pend[b] && g == 4'd0) g[b] = 1'b1;
        m_pulse = g;
        m_pend  = (m_pend & ~g) | rise;
      end else begin
        m_pulse = rise;
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_track();
    for (int b = 0; b < 4; b++) begin
      pulse_cnt[b] = 0;
      first_pulse[b] = -1;
    end
  endtask

  // One clock edge: drive on the falling edge, model the rising edge, sample 1 ns later.
  task automatic step(input logic [3:0] raw, input logic rst);
    @(negedge clk);
    btn_raw = raw;
    reset   = rst;
    @(posedge clk);
    edge_no++;
    model_edge(raw, rst);
    #1;
    check("level", btn_level, m_level);
    check("pulse", btn_pulse, m_pulse);
    for (int b = 0; b < 4; b++) begin
      if (btn_pulse[b] === 1'b1) begin
        pulse_cnt[b]++;
        if (first_pulse[b] < 0) first_pulse[b] = edge_no;
      end
    end
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int k = 0; k < n; k++) step(raw, 1'b0);
  endtask

  initial begin
    int e0;
    logic [3:0] r;
    int len;
    logic rst_now;

    // 1: reset with all buttons held, then release
    for (int k = 0; k < 3; k++) step(4'hF, 1'b1);
    check("rst_level", btn_level, 4'h0);
    check("rst_pulse", btn_pulse, 4'h0);
    clear_track();
    e0 = edge_no + 1;
    hold(4'hF, 12);
    check_int("t1_first_b0", first_pulse[0] - e0, D + 1 + ONEHOT);
    check_int("t1_first_b3", first_pulse[3] - e0, D + 1 + ONEHOT + 3 * ONEHOT);
    check_int("t1_cnt_b2", pulse_cnt[2], 1);
    hold(4'h0, 8);
    check("t1_released", btn_level, 4'h0);

    // 2: single clean press on bit 2
    clear_track();
    e0 = edge_no + 1;
    hold(4'h4, 10);
    check_int("t2_latency", first_pulse[2] - e0, D + 1 + ONEHOT);
    check_int("t2_count", pulse_cnt[2], 1);
    hold(4'h0, 8);

    // 3: bounce on bit 0, then stable
    clear_track();
    hold(4'h1, 2); hold(4'h0, 2); hold(4'h1, 2); hold(4'h0, 2);
    check_int("t3_no_bounce_pulse", pulse_cnt[0], 0);
    e0 = edge_no + 1;
    hold(4'h1, 10);
    check_int("t3_latency", first_pulse[0] - e0, D + 1 + ONEHOT);
    check_int("t3_count", pulse_cnt[0], 1);
    hold(4'h0, 8);

    // 4: press, long hold, release, press again on bit 1
    clear_track();
    hold(4'h2, 20);
    e0 = edge_no + 1;
    hold(4'h0, D + 1);
    check("t4_level_before_drop", btn_level, 4'h2);
    hold(4'h0, 1);
    check_int("t4_drop_edge", edge_no - e0, D + 1);
    check("t4_level_dropped", btn_level, 4'h0);
    hold(4'h2, 10);
    check_int("t4_count", pulse_cnt[1], 2);
    hold(4'h0, 8);

    // 5: reset while bit 3 is mid-count
    hold(4'h8, 3);
    step(4'h8, 1'b1);
    clear_track();
    e0 = edge_no + 1;
    hold(4'h8, 10);
    check_int("t5_latency", first_pulse[3] - e0, D + 1 + ONEHOT);
    check_int("t5_count", pulse_cnt[3], 1);
    hold(4'h0, 8);

    // 6: simultaneous press of bits 0 and 3
    clear_track();
    hold(4'h9, 12);
    check_int("t6_gap", first_pulse[3] - first_pulse[0], ONEHOT);
    check_int("t6_cnt_b0", pulse_cnt[0], 1);
    hold(4'h0, 8);

    // 7: random press patterns with occasional reset
    for (int n = 0; n < 60; n++) begin
      r = 4'($urandom);
      len = $urandom_range(1, 9);
      rst_now = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < len; k++) step(r, rst_now && (k == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
